// File: rtl/fighter_pkg.sv
// Shared types and constants for the two-fighter scene: jump states, palette
// and the coordinate width used by every position register.
package fighter_pkg;

   localparam int CW = 10;
   localparam int GW = CW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2
   } jump_state_t;

   localparam logic [23:0] COL_P0    = 24'hFF0000;
   localparam logic [23:0] COL_P1    = 24'h0000FF;
   localparam logic [23:0] COL_FLOOR = 24'h008000;
   localparam logic [23:0] COL_BG    = 24'h202020;

   // Half-open span test done one bit wider so lo+len can never wrap.
   function automatic logic in_span(logic [CW-1:0] pos, logic [CW-1:0] lo,
                                    logic [GW-1:0] len);
      return ({1'b0, pos} >= {1'b0, lo}) && ({1'b0, pos} < ({1'b0, lo} + len));
   endfunction

endpackage

// File: rtl/fighter_player.sv
// One fighter: jump FSM with its y register, plus the clamped horizontal
// candidate that the scene arbitrates before committing x.
//
// state | meaning
// IDLE  | standing on the floor, a jump press starts RISE
// RISE  | moving up SPEED per tick until the apex
// FALL  | moving down SPEED per tick until back on the floor
module fighter_player import fighter_pkg::*; #(
   parameter int H_RES   = 640,
   parameter int BOX_W   = 40,
   parameter int FLOOR_Y = 400,
   parameter int SPEED   = 4,
   parameter int JUMP_H  = 80
) (
   input  logic          clk_pix,
   input  logic          sim_rst,
   input  logic          tick,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_jump,
   input  logic [CW-1:0] x,
   output logic [CW-1:0] x_cand,
   output logic [CW-1:0] y,
   output jump_state_t   state
);

   localparam logic [GW-1:0] X_MAX   = GW'(H_RES - BOX_W);
   localparam logic [GW-1:0] X_STEP  = GW'(SPEED);
   localparam logic [CW-1:0] Y_FLOOR = CW'(FLOOR_Y);
   localparam logic [CW-1:0] Y_APEX  = CW'(FLOOR_Y - JUMP_H);
   localparam logic [CW-1:0] Y_STEP  = CW'(SPEED);

   logic [GW-1:0] x_next;
   logic [CW-1:0] y_up;
   logic [CW-1:0] y_dn;

   // Left saturates at zero rather than wrapping through the guard bit.
   always_comb begin
      x_next = {1'b0, x};
      if (btn_left && !btn_right)
         x_next = ({1'b0, x} < X_STEP) ? '0 : {1'b0, x} - X_STEP;
      else if (btn_right && !btn_left)
         x_next = {1'b0, x} + X_STEP;
      if (x_next > X_MAX)
         x_next = X_MAX;
   end

   assign x_cand = x_next[CW-1:0];
   assign y_up   = y - Y_STEP;
   assign y_dn   = y + Y_STEP;

   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         state <= IDLE;
         y     <= Y_FLOOR;
      end else if (tick) begin
         case (state)
            IDLE: begin
               y <= Y_FLOOR;
               if (btn_jump)
                  state <= RISE;
            end
            RISE: begin
               y <= y_up;
               if (y_up == Y_APEX)
                  state <= FALL;
            end
            FALL: begin
               y <= y_dn;
               if (y_dn == Y_FLOOR)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               y     <= Y_FLOOR;
            end
         endcase
      end
   end

endmodule

// File: rtl/fighter_scene.sv
// Two-player fighter scene: raster scanner, per-frame position update with
// non-overlap arbitration, and a single registered pixel output stage.
module fighter_scene import fighter_pkg::*; #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int BOX_W   = 40,
   parameter int BOX_H   = 40,
   parameter int FLOOR_Y = 400,
   parameter int SPEED   = 4,
   parameter int JUMP_H  = 80
) (
   input  logic          clk_pix,
   input  logic          sim_rst,
   input  logic [1:0]    btn_left,
   input  logic [1:0]    btn_right,
   input  logic [1:0]    btn_jump,
   output logic [CW-1:0] sdl_sx,
   output logic [CW-1:0] sdl_sy,
   output logic          sdl_de,
   output logic [7:0]    sdl_r,
   output logic [7:0]    sdl_g,
   output logic [7:0]    sdl_b
);

   localparam logic [CW-1:0] SX_MAX     = CW'(H_RES - 1);
   localparam logic [CW-1:0] SY_MAX     = CW'(V_RES - 1);
   localparam logic [CW-1:0] X1_INIT    = CW'(H_RES - BOX_W);
   localparam logic [GW-1:0] BOX_WG     = GW'(BOX_W);
   localparam logic [GW-1:0] BOX_HG     = GW'(BOX_H);
   localparam logic [GW-1:0] FLOOR_BAND = GW'(FLOOR_Y + BOX_H);

   logic [CW-1:0] sx, sy;
   logic          frame_tick;
   logic [CW-1:0] x0, x1, c0, c1, y0, y1;
   jump_state_t   st0, st1;
   logic          overlap;
   logic [23:0]   rgb;

   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         sx <= '0;
         sy <= '0;
      end else if (sx == SX_MAX) begin
         sx <= '0;
         sy <= (sy == SY_MAX) ? '0 : sy + 1'b1;
      end else begin
         sx <= sx + 1'b1;
      end
   end

   assign frame_tick = (sx == SX_MAX) && (sy == SY_MAX);

   fighter_player #(
      .H_RES(H_RES), .BOX_W(BOX_W), .FLOOR_Y(FLOOR_Y), .SPEED(SPEED), .JUMP_H(JUMP_H)
   ) u_p0 (
      .clk_pix(clk_pix), .sim_rst(sim_rst), .tick(frame_tick),
      .btn_left(btn_left[0]), .btn_right(btn_right[0]), .btn_jump(btn_jump[0]),
      .x(x0), .x_cand(c0), .y(y0), .state(st0)
   );

   fighter_player #(
      .H_RES(H_RES), .BOX_W(BOX_W), .FLOOR_Y(FLOOR_Y), .SPEED(SPEED), .JUMP_H(JUMP_H)
   ) u_p1 (
      .clk_pix(clk_pix), .sim_rst(sim_rst), .tick(frame_tick),
      .btn_left(btn_left[1]), .btn_right(btn_right[1]), .btn_jump(btn_jump[1]),
      .x(x1), .x_cand(c1), .y(y1), .state(st1)
   );

   // P0 is always on the left; any contact violation freezes both players.
   assign overlap = ({1'b0, c0} + BOX_WG) > {1'b0, c1};

   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         x0 <= '0;
         x1 <= X1_INIT;
      end else if (frame_tick && !overlap) begin
         x0 <= c0;
         x1 <= c1;
      end
   end

   always_comb begin
      rgb = COL_BG;
      if (in_span(sx, x0, BOX_WG) && in_span(sy, y0, BOX_HG))
         rgb = COL_P0;
      else if (in_span(sx, x1, BOX_WG) && in_span(sy, y1, BOX_HG))
         rgb = COL_P1;
      else if ({1'b0, sy} >= FLOOR_BAND)
         rgb = COL_FLOOR;
   end

   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         sdl_sx <= '0;
         sdl_sy <= '0;
         sdl_de <= 1'b0;
         sdl_r  <= '0;
         sdl_g  <= '0;
         sdl_b  <= '0;
      end else begin
         sdl_sx <= sx;
         sdl_sy <= sy;
         sdl_de <= 1'b1;
         sdl_r  <= rgb[23:16];
         sdl_g  <= rgb[15:8];
         sdl_b  <= rgb[7:0];
      end
   end

endmodule

// File: tb/tb_fighter_scene.sv
// Bench for fighter_scene on a shrunken 32x16 raster so each frame is short;
// positions follow a hand-computed vector table plus a few timed sequences.
module tb_fighter_scene;
   import fighter_pkg::*;

   localparam int TH    = 32;
   localparam int TV    = 16;
   localparam int TW    = 5;
   localparam int TBH   = 3;
   localparam int TFY   = 10;
   localparam int TSP   = 2;
   localparam int TJH   = 4;
   localparam int FRAME = TH * TV;

   logic       clk_pix = 1'b0;
   logic       sim_rst = 1'b1;
   logic [1:0] btn_left = '0, btn_right = '0, btn_jump = '0;
   logic [9:0] sdl_sx, sdl_sy;
   logic       sdl_de;
   logic [7:0] sdl_r, sdl_g, sdl_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   fighter_scene #(
      .H_RES(TH), .V_RES(TV), .BOX_W(TW), .BOX_H(TBH),
      .FLOOR_Y(TFY), .SPEED(TSP), .JUMP_H(TJH)
   ) u_dut (
      .clk_pix(clk_pix), .sim_rst(sim_rst),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .sdl_sx(sdl_sx), .sdl_sy(sdl_sy), .sdl_de(sdl_de),
      .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b)
   );

   always #5 clk_pix = ~clk_pix;

   // Clock edges since the last reset release; tick k lands on cyc == k*FRAME.
   always @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   typedef struct {
      logic [1:0]  l, r, j;
      int          x0, x1, y0, y1;
      jump_state_t st1;
   } vec_t;

   typedef struct {
      int          px, py;
      logic [23:0] rgb;
   } pix_t;

   vec_t vecs[$];
   pix_t pixs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic add_vec(input logic [1:0] l, input logic [1:0] r, input logic [1:0] j,
                          input int x0, input int x1, input int y0, input int y1,
                          input jump_state_t st1);
      vec_t v;
      v.l = l; v.r = r; v.j = j;
      v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1; v.st1 = st1;
      vecs.push_back(v);
   endtask

   task automatic add_pix(input int px, input int py, input logic [23:0] rgb);
      pix_t p;
      p.px = px; p.py = py; p.rgb = rgb;
      pixs.push_back(p);
   endtask

   task automatic next_tick();
      int target;
      target = (cyc / FRAME + 1) * FRAME;
      while (cyc < target) @(negedge clk_pix);
   endtask

   task automatic check_pixel(input string name, input int px, input int py,
                              input logic [23:0] rgb);
      int n = 0;
      while (!(sdl_de && int'(sdl_sx) == px && int'(sdl_sy) == py) && n < FRAME + 4) begin
         @(negedge clk_pix);
         n++;
      end
      if (n >= FRAME + 4) chk({name, " timeout"}, 0, 1);
      else                chk(name, int'({sdl_r, sdl_g, sdl_b}), int'(rgb));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " sdl_sx"}, int'(sdl_sx), 0);
      chk({tag, " sdl_sy"}, int'(sdl_sy), 0);
      chk({tag, " sdl_de"}, int'(sdl_de), 0);
      chk({tag, " sdl_rgb"}, int'({sdl_r, sdl_g, sdl_b}), 0);
      chk({tag, " x0"}, int'(u_dut.x0), 0);
      chk({tag, " x1"}, int'(u_dut.x1), TH - TW);
      chk({tag, " y0"}, int'(u_dut.y0), TFY);
      chk({tag, " y1"}, int'(u_dut.y1), TFY);
      chk({tag, " st1"}, int'(u_dut.st1), int'(IDLE));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Pixels of the first frame, in scan order: P0 at (0,10), P1 at (27,10).
      add_pix(15, 3,  COL_BG);
      add_pix(0,  10, COL_P0);
      add_pix(26, 10, COL_BG);
      add_pix(27, 10, COL_P1);
      add_pix(4,  12, COL_P0);
      add_pix(5,  12, COL_BG);
      add_pix(31, 12, COL_P1);
      add_pix(0,  13, COL_FLOOR);
      add_pix(15, 14, COL_FLOOR);

      //       left   right  jump   x0  x1  y0  y1  st1
      add_vec(2'b00, 2'b00, 2'b00,  0, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b01, 2'b00,  2, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b01, 2'b00,  4, 27, 10, 10, IDLE);
      add_vec(2'b01, 2'b00, 2'b00,  2, 27, 10, 10, IDLE);
      add_vec(2'b01, 2'b00, 2'b00,  0, 27, 10, 10, IDLE);
      add_vec(2'b01, 2'b00, 2'b00,  0, 27, 10, 10, IDLE);
      add_vec(2'b01, 2'b01, 2'b00,  0, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b10, 2'b00,  0, 27, 10, 10, IDLE);
      add_vec(2'b10, 2'b00, 2'b00,  0, 25, 10, 10, IDLE);
      add_vec(2'b00, 2'b10, 2'b00,  0, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b10,  0, 27, 10, 10, RISE);
      add_vec(2'b00, 2'b00, 2'b10,  0, 27, 10,  8, RISE);
      add_vec(2'b00, 2'b00, 2'b00,  0, 27, 10,  6, FALL);
      add_vec(2'b00, 2'b00, 2'b10,  0, 27, 10,  8, FALL);
      add_vec(2'b00, 2'b00, 2'b10,  0, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b10,  0, 27, 10, 10, RISE);
      add_vec(2'b00, 2'b01, 2'b00,  2, 27, 10,  8, RISE);
      add_vec(2'b00, 2'b01, 2'b00,  4, 27, 10,  6, FALL);
      add_vec(2'b00, 2'b01, 2'b00,  6, 27, 10,  8, FALL);
      add_vec(2'b00, 2'b01, 2'b00,  8, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b01,  8, 27, 10, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b00,  8, 27,  8, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b00,  8, 27,  6, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b00,  8, 27,  8, 10, IDLE);
      add_vec(2'b00, 2'b00, 2'b00,  8, 27, 10, 10, IDLE);
      // Walk P0 right until it touches P1 at x0 = 27 - 5 = 22, then stall there.
      for (int k = 1; k <= 9; k++)
         add_vec(2'b00, 2'b01, 2'b00, (8 + 2 * k > 22) ? 22 : 8 + 2 * k, 27, 10, 10, IDLE);
      add_vec(2'b10, 2'b01, 2'b00, 22, 27, 10, 10, IDLE);
      add_vec(2'b10, 2'b00, 2'b00, 22, 27, 10, 10, IDLE);
      add_vec(2'b11, 2'b00, 2'b00, 20, 25, 10, 10, IDLE);
      add_vec(2'b00, 2'b11, 2'b00, 22, 27, 10, 10, IDLE);
      add_vec(2'b01, 2'b10, 2'b00, 20, 27, 10, 10, IDLE);

      repeat (3) @(negedge clk_pix);
      check_reset_state("rst0");
      sim_rst = 1'b0;

      while (cyc < 40) @(negedge clk_pix);
      chk("pipe sdl_sx", int'(sdl_sx), (40 - 1) % TH);
      chk("pipe sdl_sy", int'(sdl_sy), ((40 - 1) / TH) % TV);
      chk("pipe sdl_de", int'(sdl_de), 1);

      foreach (pixs[i])
         check_pixel($sformatf("pix(%0d,%0d)", pixs[i].px, pixs[i].py),
                     pixs[i].px, pixs[i].py, pixs[i].rgb);

      foreach (vecs[i]) begin
         btn_left  = vecs[i].l;
         btn_right = vecs[i].r;
         btn_jump  = vecs[i].j;
         next_tick();
         chk($sformatf("vec%0d x0", i), int'(u_dut.x0), vecs[i].x0);
         chk($sformatf("vec%0d x1", i), int'(u_dut.x1), vecs[i].x1);
         chk($sformatf("vec%0d y0", i), int'(u_dut.y0), vecs[i].y0);
         chk($sformatf("vec%0d y1", i), int'(u_dut.y1), vecs[i].y1);
         chk($sformatf("vec%0d st1", i), int'(u_dut.st1), int'(vecs[i].st1));
      end
      btn_left = '0; btn_right = '0; btn_jump = '0;

      // A press that starts and ends between two ticks must not move anyone.
      repeat (100) @(negedge clk_pix);
      btn_right = 2'b01;
      btn_jump  = 2'b11;
      repeat (50) @(negedge clk_pix);
      btn_right = '0;
      btn_jump  = '0;
      next_tick();
      chk("midframe x0", int'(u_dut.x0), 20);
      chk("midframe st0", int'(u_dut.st0), int'(IDLE));
      chk("midframe st1", int'(u_dut.st1), int'(IDLE));

      // Moved P0 is drawn at its new x on the following frame.
      check_pixel("pix moved p0", 20, 10, COL_P0);
      check_pixel("pix moved gap", 25, 11, COL_BG);

      // Jump P1 to its apex, then reset in the middle of a frame.
      btn_jump = 2'b10;
      next_tick();
      btn_jump = '0;
      next_tick();
      next_tick();
      chk("apex y1", int'(u_dut.y1), TFY - TJH);
      chk("apex st1", int'(u_dut.st1), int'(FALL));
      repeat (37) @(negedge clk_pix);
      #1 sim_rst = 1'b1;
      #1 check_reset_state("rst_apex");
      chk("rst_apex sx", int'(u_dut.sx), 0);
      @(negedge clk_pix);
      sim_rst = 1'b0;

      while (cyc < FRAME - 2) @(negedge clk_pix);
      chk("tick early", int'(u_dut.frame_tick), 0);
      @(negedge clk_pix);
      chk("tick first", int'(u_dut.frame_tick), 1);
      @(negedge clk_pix);
      chk("tick single", int'(u_dut.frame_tick), 0);
      chk("post rst y1", int'(u_dut.y1), TFY);
      chk("post rst x0", int'(u_dut.x0), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fighter_scene.md
FIGHTER_SCENE -- requirements
Module: fighter_scene

Interface
REQ-001 H_RES, 640, active pixels per line; scanner X range 0..H_RES-1.
REQ-002 V_RES, 480, active lines per frame; scanner Y range 0..V_RES-1.
REQ-003 BOX_W, 40, fighter width in pixels.
REQ-004 BOX_H, 40, fighter height in pixels.
REQ-005 FLOOR_Y, 400, fighter top-Y when standing.
REQ-006 SPEED, 4, pixels moved per frame tick, horizontal and vertical; JUMP_H SHALL be a multiple of SPEED.
REQ-007 JUMP_H, 80, jump apex height above FLOOR_Y.
REQ-008 clk_pix  in  1  pixel clock.
REQ-009 sim_rst  in  1  reset, asynchronous, active-high.
REQ-010 btn_left  in  2  per-player move left, bit0 = P0, bit1 = P1.
REQ-011 btn_right  in  2  per-player move right.
REQ-012 btn_jump  in  2  per-player jump request.
REQ-013 sdl_sx, sdl_sy  out  10 each  registered pixel coordinate.
REQ-014 sdl_de  out  1  registered draw enable.
REQ-015 sdl_r, sdl_g, sdl_b  out  8 each  registered colour.

Function
REQ-016 Scanner: sx increments each clk_pix; at H_RES-1 it wraps to 0 and sy increments; sy wraps from V_RES-1 to 0.
REQ-017 frame_tick SHALL pulse exactly one cycle when sx==H_RES-1 and sy==V_RES-1; positions and FSMs update only on frame_tick.
REQ-018 Buttons are sampled only on frame_tick; presses between ticks SHALL have no effect.
REQ-019 Horizontal candidate per player: left only -> x-SPEED, right only -> x+SPEED, both or neither -> x unchanged.
REQ-020 Candidate X SHALL be clamped to [0, H_RES-BOX_W], with no underflow wrap (x < SPEED moving left -> 0).
REQ-021 Non-overlap: if clamped candidates give x0+BOX_W > x1, both players SHALL keep their old X; otherwise both take their candidates.
REQ-022 Jump FSM per player, states IDLE, RISE, FALL.
REQ-023 IDLE with btn_jump -> RISE; y stays FLOOR_Y in IDLE.
REQ-024 RISE: y -= SPEED per tick; when the new y equals FLOOR_Y-JUMP_H -> FALL.
REQ-025 FALL: y += SPEED per tick; when the new y equals FLOOR_Y -> IDLE.
REQ-026 btn_jump in RISE or FALL is ignored, so there is no double jump; a held jump re-triggers on the first tick after returning to IDLE.
REQ-027 Horizontal movement is allowed in every FSM state.
REQ-028 Output pipeline: one register stage; sdl_sx/sdl_sy/sdl_de/rgb at cycle n+1 correspond to scanner position at cycle n.
REQ-029 sdl_de = 1 for every scanned pixel after the first post-reset cycle.
REQ-030 Colour priority per pixel:
- P0 box (x0<=sx<x0+BOX_W, y0<=sy<y0+BOX_H): FF0000
- else P1 box: 0000FF
- else sy >= FLOOR_Y+BOX_H: 008000
- else 202020
REQ-031 All coordinate arithmetic SHALL use 10 bits plus one guard bit for comparisons, so sums never wrap.

Reset
REQ-032 On sim_rst assertion, immediately: sx=sy=0, x0=0, x1=H_RES-BOX_W, y0=y1=FLOOR_Y, both FSMs IDLE.
REQ-033 On sim_rst assertion, all sdl_* outputs SHALL be 0, including sdl_de=0.
REQ-034 Reset mid-jump or mid-frame SHALL abort to the REQ-032 state; no tick is issued until a full frame has been scanned after release.

Structure
REQ-035 Package fighter_pkg SHALL hold the jump-state enum (IDLE/RISE/FALL), the four colour constants and the coordinate width constant.
REQ-036 Sub-module fighter_player, instantiated twice, SHALL contain the jump FSM, y register and clamped horizontal candidate.
REQ-037 The top level SHALL hold the scanner, the non-overlap arbitration, x registers and the output pipeline.

Verification
REQ-038 Reset then 1 frame idle -> pixel (0,400) red, (600,400) blue, (300,450) green, (300,100) 202020.
REQ-039 btn_right[0] held 10 frames -> x0=40; held until x0+40 >= x1-... -> P0 stops at x0=560 (touching x1=600), never overlaps.
REQ-040 btn_left[0] held from x0=0 -> x0 stays 0, no wrap to ~1020.
REQ-041 btn_jump[1] one tick -> y1 = 396,392,...,320 (RISE, 20 ticks), then back to 400 over 20 ticks, IDLE; a jump pressed at tick 5 is ignored.
REQ-042 Both players adjacent (x0=560, x1=600), P0 right and P1 left on the same tick -> both X unchanged.
REQ-043 sim_rst asserted at the apex of a jump -> outputs 0 the same cycle; after release y1=400, IDLE; the first tick occurs exactly H_RES*V_RES cycles later.
